// File: rtl/AHB_package.sv
// Shared types and constants for the AHB_Gen master-port response path.
//   htrans_t   : AHB HTRANS encoding
//   dp_state_t : data-phase tracker states of the response router
//   SLV_PAYLOAD: slave response payload width ({HRESP, HRDATA})
//   HRESP_BIT  : position of HRESP inside the payload (1 = ERROR)
package AHB_package;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        DP_IDLE  = 2'b00,
        DP_SLAVE = 2'b01,
        DP_ERR1  = 2'b10,
        DP_ERR2  = 2'b11
    } dp_state_t;

    localparam int SLV_PAYLOAD = 33;
    localparam int HRESP_BIT   = 32;

endpackage

// File: rtl/ahb_onehot_enc.sv
// One-hot to binary encoder.
//   onehot : input vector, expected to have at most one bit set
//   valid  : high when exactly one bit of onehot is set
//   index  : binary position of the set bit (meaningful only when valid)
module ahb_onehot_enc #(
    parameter int CHANNEL_NUM = 2,
    parameter int IDX_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
    input  logic [CHANNEL_NUM-1:0] onehot,
    output logic                   valid,
    output logic [IDX_W-1:0]       index
);

    logic any_set;
    logic multi_set;

    // Single pass: a set bit seen after another set bit flags a multi-hot
    // vector; OR-ing the indices is exact whenever only one bit is set.
    always_comb begin
        any_set   = 1'b0;
        multi_set = 1'b0;
        index     = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (onehot[i]) begin
                multi_set = multi_set | any_set;
                any_set   = 1'b1;
                index     = index | IDX_W'(i);
            end
        end
        valid = any_set & ~multi_set;
    end

endmodule

// File: rtl/ahb_si_resp_router.sv
// Data-phase response router for one master port.
// Records which slave owns each accepted address phase and steers that
// slave's {HRESP, HRDATA} payload and HREADYOUT back to the master during
// the data phase. Includes a default slave: zero-wait OKAY for IDLE/BUSY
// and a two-cycle ERROR for decode misses (no or multiple hsel bits).
//   hclk, hreset_n : clock, synchronous active-low reset
//   htrans         : master HTRANS of the current address phase
//   hsel_addr      : one-hot decoder output for the current address phase
//   payload_in     : per-slave response payloads
//   hreadyout_in   : per-slave HREADYOUT
//   payload_out    : response payload to the master
//   hready_out     : HREADY to the master and all slaves on this port
//   dp_sel         : registered one-hot data-phase owner (0 = none)
module ahb_si_resp_router
    import AHB_package::*;
#(
    parameter int CHANNEL_NUM = 2,
    parameter int PAY_LOAD    = SLV_PAYLOAD
) (
    input  logic                                hclk,
    input  logic                                hreset_n,
    input  logic [1:0]                          htrans,
    input  logic [CHANNEL_NUM-1:0]              hsel_addr,
    input  logic [CHANNEL_NUM-1:0][PAY_LOAD-1:0] payload_in,
    input  logic [CHANNEL_NUM-1:0]              hreadyout_in,
    output logic [PAY_LOAD-1:0]                 payload_out,
    output logic                                hready_out,
    output logic [CHANNEL_NUM-1:0]              dp_sel
);

    localparam int IDX_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam logic [PAY_LOAD-1:0] ERR_PAYLOAD = PAY_LOAD'(1) << HRESP_BIT;

    dp_state_t              state_q,  state_d;
    logic [CHANNEL_NUM-1:0] dp_sel_q, dp_sel_d;

    logic             addr_valid;
    logic [IDX_W-1:0] addr_idx;
    logic             dp_valid;
    logic [IDX_W-1:0] dp_idx;
    logic             active_trans;

    ahb_onehot_enc #(.CHANNEL_NUM(CHANNEL_NUM)) u_addr_enc (
        .onehot (hsel_addr),
        .valid  (addr_valid),
        .index  (addr_idx)
    );

    ahb_onehot_enc #(.CHANNEL_NUM(CHANNEL_NUM)) u_dp_enc (
        .onehot (dp_sel_q),
        .valid  (dp_valid),
        .index  (dp_idx)
    );

    assign active_trans = (htrans_t'(htrans) == NONSEQ) || (htrans_t'(htrans) == SEQ);

    // Response path: purely combinational from registered ownership.
    always_comb begin
        payload_out = '0;
        hready_out  = 1'b1;
        unique case (state_q)
            DP_IDLE: begin
                payload_out = '0;
                hready_out  = 1'b1;
            end
            DP_SLAVE: begin
                if (dp_valid) begin
                    payload_out = payload_in[dp_idx];
                    hready_out  = hreadyout_in[dp_idx];
                end
            end
            DP_ERR1: begin
                payload_out = ERR_PAYLOAD;
                hready_out  = 1'b0;
            end
            DP_ERR2: begin
                payload_out = ERR_PAYLOAD;
                hready_out  = 1'b1;
            end
            default: begin
                payload_out = '0;
                hready_out  = 1'b1;
            end
        endcase
    end

    // Next-state: ERR1 always advances; otherwise a low hready_out holds,
    // and a high hready_out accepts the current address phase.
    always_comb begin
        state_d  = state_q;
        dp_sel_d = dp_sel_q;
        if (state_q == DP_ERR1) begin
            state_d  = DP_ERR2;
            dp_sel_d = '0;
        end else if (hready_out) begin
            if (!active_trans) begin
                state_d  = DP_IDLE;
                dp_sel_d = '0;
            end else if (addr_valid) begin
                state_d  = DP_SLAVE;
                dp_sel_d = hsel_addr;
            end else begin
                state_d  = DP_ERR1;
                dp_sel_d = '0;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state_q  <= DP_IDLE;
            dp_sel_q <= '0;
        end else begin
            state_q  <= state_d;
            dp_sel_q <= dp_sel_d;
        end
    end

    assign dp_sel = dp_sel_q;

    // addr_idx is not needed: hsel_addr itself is already the one-hot owner.
    logic unused_addr_idx;
    assign unused_addr_idx = ^addr_idx;

endmodule
